// File: rtl/kitchen_timer_pkg.sv
// Shared types and helpers for the kitchen timer engine.
// Optional alarm feature is selected with macro KITCHEN_TIMER_ALARM_EN.
package kitchen_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int SEC_MAX = 59;
  localparam int BCD_W   = 16;

  // Binary 0..99 to {tens, ones} BCD digits.
  function automatic logic [7:0] bin2bcd(input logic [6:0] i_val);
    return {4'(i_val / 7'd10), 4'(i_val % 7'd10)};
  endfunction

endpackage

// File: rtl/kitchen_timer_if.sv
// Control/status bundle between the timer engine and its controller.
// Controls are plain levels sampled on every clk edge (no handshake):
// clear > stop > start > set_min > set_sec when several are high together.
interface kitchen_timer_if;
  import kitchen_timer_pkg::*;

  logic [6:0]       num;
  logic             set_min;
  logic             set_sec;
  logic             mode;
  logic             start;
  logic             stop;
  logic             clear;
  logic [BCD_W-1:0] bcd;
  logic             running;
  logic             done;
  logic             alarm;
  state_t           dbg_state;

  modport master (
    output num, set_min, set_sec, mode, start, stop, clear,
    input  bcd, running, done, alarm, dbg_state
  );

  modport slave (
    input  num, set_min, set_sec, mode, start, stop, clear,
    output bcd, running, done, alarm, dbg_state
  );

endinterface

// File: rtl/kitchen_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV enabled cycles.
// The count holds while disabled, so a paused run resumes mid-second.
module kitchen_tick_gen #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_tick = i_enable && (r_cnt == LAST);

  // Prescaler counter: clear wins, then wrap at LAST while enabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/kitchen_timer_core.sv
// Minute/second up/down timer with start/pause/resume/clear and BCD output.
// Macro KITCHEN_TIMER_ALARM_EN adds a timed alarm pulse on DONE entry;
// without it the alarm output mirrors done.
module kitchen_timer_core
  import kitchen_timer_pkg::*;
#(
  parameter int TICK_DIV  = 50000000,
  parameter int MAX_MIN   = 99,
  parameter int ALARM_SEC = 5
) (
  input  logic            clk,
  input  logic            reset,
  kitchen_timer_if.slave  bus
);

  state_t           r_state;
  state_t           w_state_nx;
  logic [6:0]       r_pre_min;
  logic [5:0]       r_pre_sec;
  logic [6:0]       r_min;
  logic [5:0]       r_sec;
  logic             r_mode;
  logic [BCD_W-1:0] r_bcd;
  logic             r_running;
  logic             r_done;

  logic       w_clear, w_stop, w_start, w_set_min, w_set_sec;
  logic       w_go, w_tick, w_presc_en, w_presc_clr, w_end;
  logic [6:0] w_pre_min_nx;
  logic [5:0] w_pre_sec_nx;
  logic [6:0] w_dn_min, w_up_min;
  logic [5:0] w_dn_sec, w_up_sec;

  // Control priority decode.
  assign w_clear   = bus.clear;
  assign w_stop    = bus.stop & ~bus.clear;
  assign w_start   = bus.start & ~bus.stop & ~bus.clear;
  assign w_set_min = bus.set_min & ~bus.start & ~bus.stop & ~bus.clear;
  assign w_set_sec = bus.set_sec & ~bus.set_min & ~bus.start & ~bus.stop & ~bus.clear;

  // A down count from 00:00 would finish instantly, so that start is refused.
  assign w_go = (r_state == IDLE) && w_start &&
                !(!bus.mode && (r_pre_min == 7'd0) && (r_pre_sec == 6'd0));

  // Presets only change in IDLE and are clamped to their legal range.
  assign w_pre_min_nx = ((r_state == IDLE) && w_set_min) ?
                        ((bus.num > 7'(MAX_MIN)) ? 7'(MAX_MIN) : bus.num) : r_pre_min;
  assign w_pre_sec_nx = ((r_state == IDLE) && w_set_sec) ?
                        ((bus.num > 7'(SEC_MAX)) ? 6'(SEC_MAX) : bus.num[5:0]) : r_pre_sec;

  // Next count values for one tick in either direction.
  assign w_dn_sec = (r_sec == 6'd0) ? 6'(SEC_MAX) : r_sec - 6'd1;
  assign w_dn_min = (r_sec == 6'd0) ? r_min - 7'd1 : r_min;
  assign w_up_sec = (r_sec == 6'(SEC_MAX)) ? 6'd0 : r_sec + 6'd1;
  assign w_up_min = (r_sec == 6'(SEC_MAX)) ? r_min + 7'd1 : r_min;
  assign w_end    = r_mode ? ((w_up_min == 7'(MAX_MIN)) && (w_up_sec == 6'(SEC_MAX)))
                           : ((w_dn_min == 7'd0) && (w_dn_sec == 6'd0));

  // A stop or clear cycle does not advance the prescaler.
`ifdef KITCHEN_TIMER_ALARM_EN
  assign w_presc_en = (((r_state == RUN) && !w_stop) || (r_state == DONE)) && !w_clear;
`else
  assign w_presc_en = (r_state == RUN) && !w_stop && !w_clear;
`endif
  assign w_presc_clr = w_go;

  kitchen_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_presc_clr),
    .i_enable (w_presc_en),
    .o_tick   (w_tick)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:  if (w_go) w_state_nx = RUN;
      RUN: begin
        if (w_clear)            w_state_nx = IDLE;
        else if (w_stop)        w_state_nx = PAUSE;
        else if (w_tick && w_end) w_state_nx = DONE;
      end
      PAUSE: begin
        if (w_clear)      w_state_nx = IDLE;
        else if (w_start) w_state_nx = RUN;
      end
      DONE:  if (w_clear) w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // Presets, mode latch and the binary minute/second count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pre_min <= '0;
      r_pre_sec <= '0;
      r_min     <= '0;
      r_sec     <= '0;
      r_mode    <= 1'b0;
    end else begin
      r_pre_min <= w_pre_min_nx;
      r_pre_sec <= w_pre_sec_nx;
      case (r_state)
        IDLE: begin
          if (w_go) begin
            r_mode <= bus.mode;
            r_min  <= bus.mode ? 7'd0 : r_pre_min;
            r_sec  <= bus.mode ? 6'd0 : r_pre_sec;
          end else begin
            r_min  <= w_pre_min_nx;
            r_sec  <= w_pre_sec_nx;
          end
        end
        RUN: begin
          if (w_clear) begin
            r_min <= r_pre_min;
            r_sec <= r_pre_sec;
          end else if (w_tick) begin
            r_min <= r_mode ? w_up_min : w_dn_min;
            r_sec <= r_mode ? w_up_sec : w_dn_sec;
          end
        end
        default: begin
          if (w_clear) begin
            r_min <= r_pre_min;
            r_sec <= r_pre_sec;
          end
        end
      endcase
    end
  end

  // Registered display and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bcd     <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_bcd     <= {bin2bcd(r_min), bin2bcd({1'b0, r_sec})};
      r_running <= (r_state == RUN);
      r_done    <= (r_state == DONE);
    end
  end

`ifdef KITCHEN_TIMER_ALARM_EN
  localparam int AW = $clog2(ALARM_SEC + 1);
  logic [AW-1:0] r_alarm_left;
  logic          r_alarm;

  // Alarm: armed on DONE entry, counts down on ticks, dropped by clear at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_alarm_left <= '0;
      r_alarm      <= 1'b0;
    end else begin
      if ((r_state != DONE) && (w_state_nx == DONE))
        r_alarm_left <= AW'(ALARM_SEC);
      else if ((r_state == DONE) && w_tick && (r_alarm_left != '0))
        r_alarm_left <= r_alarm_left - 1'b1;
      r_alarm <= (r_state == DONE) && (r_alarm_left != '0) && !w_clear;
    end
  end

  assign bus.alarm = r_alarm;
`else
  assign bus.alarm = r_done;
`endif

  assign bus.bcd       = r_bcd;
  assign bus.running   = r_running;
  assign bus.done      = r_done;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_kitchen_timer_core.sv
// Directed bench for kitchen_timer_core (TICK_DIV=4, ALARM_SEC=2).
// Main instance uses MAX_MIN=99; a second instance uses MAX_MIN=1.
module tb_kitchen_timer_core;
  import kitchen_timer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  kitchen_timer_if bus();
  kitchen_timer_if bus_up();

  kitchen_timer_core #(.TICK_DIV(4), .MAX_MIN(99), .ALARM_SEC(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  kitchen_timer_core #(.TICK_DIV(4), .MAX_MIN(1), .ALARM_SEC(2)) dut_up (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_up)
  );

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: expected bcd values and the edge they must appear after.
  logic [15:0] exp_q[$];
  int          exp_t[$];
  logic [15:0] last_bcd = 16'h0000;
  logic        mon_en = 1'b0;

  task automatic push(input logic [15:0] v, input int t);
    exp_q.push_back(v);
    exp_t.push_back(t);
  endtask

  always @(negedge clk) begin
    if (mon_en && (bus.bcd !== last_bcd)) begin
      if (exp_q.size() == 0) begin
        chk("bcd_unexpected", {16'h0, bus.bcd}, {16'h0, last_bcd});
      end else begin
        chk("bcd_value", {16'h0, bus.bcd}, {16'h0, exp_q.pop_front()});
        chk("bcd_cycle", cyc, exp_t.pop_front());
      end
      last_bcd = bus.bcd;
    end
  end

  // ---------------- drivers ----------------
  // Drive one cycle of controls; e returns the edge that samples them.
  task automatic drive(input logic sm, input logic ss, input logic st, input logic sp,
                       input logic cl, input logic md, input logic [6:0] n, output int e);
    @(posedge clk); #1;
    bus.num = n; bus.set_min = sm; bus.set_sec = ss; bus.start = st;
    bus.stop = sp; bus.clear = cl; bus.mode = md;
    e = cyc + 1;
    @(posedge clk); #1;
    bus.set_min = 1'b0; bus.set_sec = 1'b0; bus.start = 1'b0;
    bus.stop = 1'b0; bus.clear = 1'b0;
  endtask

  task automatic drive_up(input logic sm, input logic ss, input logic st, input logic sp,
                          input logic cl, input logic md, input logic [6:0] n, output int e);
    @(posedge clk); #1;
    bus_up.num = n; bus_up.set_min = sm; bus_up.set_sec = ss; bus_up.start = st;
    bus_up.stop = sp; bus_up.clear = cl; bus_up.mode = md;
    e = cyc + 1;
    @(posedge clk); #1;
    bus_up.set_min = 1'b0; bus_up.set_sec = 1'b0; bus_up.start = 1'b0;
    bus_up.stop = 1'b0; bus_up.clear = 1'b0;
  endtask

  // Move to the falling edge after rising edge number t.
  task automatic at_edge(input int t);
    do @(negedge clk); while (cyc < t);
  endtask

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int e, s, p, r;
    reset = 1'b0;
    bus.num = '0; bus.set_min = 0; bus.set_sec = 0; bus.mode = 0;
    bus.start = 0; bus.stop = 0; bus.clear = 0;
    bus_up.num = '0; bus_up.set_min = 0; bus_up.set_sec = 0; bus_up.mode = 0;
    bus_up.start = 0; bus_up.stop = 0; bus_up.clear = 0;

    // Reset state.
    repeat (3) @(posedge clk);
    #2;
    chk("rst_bcd", bus.bcd, 16'h0000);
    chk("rst_running", bus.running, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_alarm", bus.alarm, 1'b0);
    chk("rst_state", bus.dbg_state, IDLE);
    @(negedge clk);
    reset = 1'b1;
    mon_en = 1'b1;

    // Down count from 00:03.
    drive(0, 1, 0, 0, 0, 0, 7'd3, e); push(16'h0003, e + 1);
    drive(1, 0, 0, 0, 0, 0, 7'd0, e);
    drive(0, 0, 1, 0, 0, 0, 7'd0, s);
    push(16'h0002, s + 5); push(16'h0001, s + 9); push(16'h0000, s + 13);
    at_edge(s + 1);  chk("dn_running", bus.running, 1'b1);
    at_edge(s + 12); chk("dn_done_early", bus.done, 1'b0);
    at_edge(s + 13);
    chk("dn_done", bus.done, 1'b1);
    chk("dn_running_off", bus.running, 1'b0);
    chk("dn_alarm_rise", bus.alarm, 1'b1);
    at_edge(s + 20); chk("dn_alarm_hold", bus.alarm, 1'b1);
    at_edge(s + 21);
`ifdef KITCHEN_TIMER_ALARM_EN
    chk("dn_alarm_fall", bus.alarm, 1'b0);
`else
    chk("dn_alarm_eq_done", bus.alarm, 1'b1);
`endif
    chk("dn_done_hold", bus.done, 1'b1);
    drive(0, 0, 1, 0, 0, 0, 7'd0, e);
    at_edge(e + 2); chk("done_ignores_start", bus.dbg_state, DONE);
    drive(0, 0, 0, 0, 1, 0, 7'd0, e); push(16'h0003, e + 1);
    at_edge(e + 1);
    chk("clr_state", bus.dbg_state, IDLE);
    chk("clr_done", bus.done, 1'b0);
    chk("clr_alarm", bus.alarm, 1'b0);

    // Minute wrap and pause/resume from 01:00.
    drive(1, 0, 0, 0, 0, 0, 7'd1, e); push(16'h0103, e + 1);
    drive(0, 1, 0, 0, 0, 0, 7'd0, e); push(16'h0100, e + 1);
    drive(0, 0, 1, 0, 0, 0, 7'd0, s); push(16'h0059, s + 5);
    at_edge(s + 5);
    drive(0, 0, 0, 1, 0, 0, 7'd0, p);
    at_edge(p + 1);
    chk("pause_state", bus.dbg_state, PAUSE);
    at_edge(p + 10);
    chk("pause_running", bus.running, 1'b0);
    chk("pause_bcd", bus.bcd, 16'h0059);
    drive(0, 0, 1, 0, 0, 0, 7'd0, r); push(16'h0058, r + 3);
    at_edge(r + 1); chk("resume_running", bus.running, 1'b1);
    at_edge(r + 3);
    drive(0, 0, 0, 0, 1, 0, 7'd0, e); push(16'h0100, e + 1);
    at_edge(e + 1); chk("midrun_clr_running", bus.running, 1'b0);

    // Clamping and set priority.
    drive(0, 1, 0, 0, 0, 0, 7'd75, e);  push(16'h0159, e + 1);
    drive(1, 0, 0, 0, 0, 0, 7'd120, e); push(16'h9959, e + 1);
    drive(1, 1, 0, 0, 0, 0, 7'd5, e);   push(16'h0559, e + 1);
    drive(1, 0, 0, 0, 0, 0, 7'd0, e);   push(16'h0059, e + 1);
    drive(0, 1, 0, 0, 0, 0, 7'd0, e);   push(16'h0000, e + 1);
    drive(0, 0, 1, 0, 0, 0, 7'd0, e);
    at_edge(e + 3);
    chk("zero_start_state", bus.dbg_state, IDLE);
    chk("zero_start_running", bus.running, 1'b0);

    // Short up count from 00:00, then clear.
    drive(0, 0, 1, 0, 0, 1, 7'd0, s);
    push(16'h0001, s + 5); push(16'h0002, s + 9);
    at_edge(s + 9);
    drive(0, 0, 0, 0, 1, 0, 7'd0, e); push(16'h0000, e + 1);
    at_edge(e + 1);

    // Up saturation on the MAX_MIN=1 instance.
    drive_up(1, 0, 0, 0, 0, 0, 7'd3, e);
    drive_up(0, 1, 0, 0, 0, 0, 7'd20, e);
    at_edge(e + 1); chk("up_preset_bcd", bus_up.bcd, 16'h0120);
    drive_up(0, 0, 1, 0, 0, 1, 7'd0, s);
    at_edge(s + 5);   chk("up_first", bus_up.bcd, 16'h0001);
    at_edge(s + 473); chk("up_0158", bus_up.bcd, 16'h0158);
    at_edge(s + 476);
    chk("up_done_early", bus_up.done, 1'b0);
    chk("up_running", bus_up.running, 1'b1);
    at_edge(s + 477);
    chk("up_sat_bcd", bus_up.bcd, 16'h0159);
    chk("up_done", bus_up.done, 1'b1);
    chk("up_alarm", bus_up.alarm, 1'b1);
    drive_up(0, 0, 1, 0, 0, 1, 7'd0, e);
    at_edge(e + 1);
    chk("up_start_ignored", bus_up.dbg_state, DONE);
    chk("up_hold_bcd", bus_up.bcd, 16'h0159);
    drive_up(0, 0, 0, 0, 1, 0, 7'd0, e);
    at_edge(e);
`ifdef KITCHEN_TIMER_ALARM_EN
    chk("up_clr_alarm_now", bus_up.alarm, 1'b0);
`else
    chk("up_clr_alarm_eq_done", bus_up.alarm, 1'b1);
`endif
    chk("up_clr_state", bus_up.dbg_state, IDLE);
    at_edge(e + 1);
    chk("up_clr_bcd", bus_up.bcd, 16'h0120);
    chk("up_clr_done", bus_up.done, 1'b0);
    chk("up_clr_alarm", bus_up.alarm, 1'b0);

    // Asynchronous reset in the middle of a run at 00:07.
    drive(0, 1, 0, 0, 0, 0, 7'd10, e); push(16'h0010, e + 1);
    drive(0, 0, 1, 0, 0, 0, 7'd0, s);
    push(16'h0009, s + 5); push(16'h0008, s + 9); push(16'h0007, s + 13);
    at_edge(s + 14);
    chk("pre_rst_bcd", bus.bcd, 16'h0007);
    chk("pre_rst_running", bus.running, 1'b1);
    mon_en = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("arst_bcd", bus.bcd, 16'h0000);
    chk("arst_running", bus.running, 1'b0);
    chk("arst_done", bus.done, 1'b0);
    chk("arst_state", bus.dbg_state, IDLE);
    chk("sb_drained", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    reset = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
